div_sched: RTL and testbench



---
 rtl/div_sched.sv | 145 ++++++++++++++
 tb/tb_div_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Round-robin scheduler that shares one restoring-division datapath between two requesters.
// Define DIV_ZERO_ERR_EN to add rsp_err and finish divide-by-zero requests after one cycle.
module div_sched #(
    parameter int WA = 8,
    parameter int WB = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*WA-1:0] req_a,
    input  logic [2*WB-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [WA-1:0]   rsp_q,
    output logic [WB-1:0]   rsp_r
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic            rsp_err
`endif
);

    localparam int CW = (WA > 1) ? $clog2(WA) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [WA-1:0] a_reg;
    logic [WB-1:0] b_reg;
    logic [WB-1:0] rem;
    logic [CW-1:0] cnt;
    logic          id_reg;
    logic          rr;
    logic          zdiv;

    logic          grant;
    logic [1:0]    ready_vec;
    logic          accept;
    logic [WA-1:0] sel_a;
    logic [WB-1:0] sel_b;

    // rr holds the requester served last; on a tie the other one wins.
    always_comb begin
        grant     = 1'b0;
        ready_vec = 2'b00;
        if (req_valid == 2'b11)
            grant = ~rr;
        else
            grant = req_valid[1];
        if (state == IDLE && rst_n && req_valid != 2'b00)
            ready_vec = grant ? 2'b10 : 2'b01;
    end

    assign req_ready = ready_vec;
    assign accept    = |(req_valid & ready_vec);
    assign sel_a     = grant ? req_a[WA +: WA] : req_a[0 +: WA];
    assign sel_b     = grant ? req_b[WB +: WB] : req_b[0 +: WB];

    logic [WB:0]   trial;
    logic          qbit;
    logic [WB-1:0] rem_sub;
    logic [WB-1:0] rem_next;
    logic [WA-1:0] a_next;

    // One restoring step; the subtraction only needs the low WB bits since the result is < B.
    assign trial    = {rem, a_reg[WA-1]};
    assign qbit     = (trial >= {1'b0, b_reg});
    assign rem_sub  = trial[WB-1:0] - b_reg;
    assign rem_next = qbit ? rem_sub : trial[WB-1:0];
    assign a_next   = {a_reg[WA-2:0], qbit};

    assign rsp_id = id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            rem       <= '0;
            cnt       <= '0;
            id_reg    <= 1'b0;
            rr        <= 1'b1;
            zdiv      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_r     <= '0;
`ifdef DIV_ZERO_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= sel_a;
                        b_reg  <= sel_b;
                        rem    <= '0;
                        id_reg <= grant;
                        rr     <= grant;
                        state  <= RUN;
`ifdef DIV_ZERO_ERR_EN
                        // A zero divisor skips the datapath and reports after a single cycle.
                        if (sel_b == '0) begin
                            zdiv <= 1'b1;
                            cnt  <= '0;
                        end else begin
                            zdiv <= 1'b0;
                            cnt  <= CW'(WA - 1);
                        end
`else
                        zdiv <= 1'b0;
                        cnt  <= CW'(WA - 1);
`endif
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    rem   <= rem_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_q     <= zdiv ? '0 : a_next;
                        rsp_r     <= zdiv ? '0 : rem_next;
`ifdef DIV_ZERO_ERR_EN
                        rsp_err   <= zdiv;
`endif
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Randomized scoreboard bench for div_sched; the reference model divides with plain arithmetic.
// Build with DIV_ZERO_ERR_EN defined to exercise the early divide-by-zero response.
module tb_div_sched;

    localparam int WA = 8;
    localparam int WB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*WA-1:0] req_a = '0;
    logic [2*WB-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [WA-1:0]   rsp_q;
    logic [WB-1:0]   rsp_r;
`ifdef DIV_ZERO_ERR_EN
    logic            rsp_err;
`endif

    div_sched #(.WA(WA), .WB(WB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_q    (rsp_q),
        .rsp_r    (rsp_r)
`ifdef DIV_ZERO_ERR_EN
        ,
        .rsp_err  (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          id;
        logic [WA-1:0] q;
        logic [WB-1:0] r;
        logic          err;
        int            due;
    } exp_t;

    exp_t sb[$];
    bit   seen = 0;
    int   checks = 0;
    int   errors = 0;

    // Model state: whether a request is outstanding, cycles until its response, last winner.
    bit   busy = 0;
    int   left = 0;
    bit   last = 1;
    int   stall = 0;
    int   next_stall = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t expectOf(input logic id, input logic [WA-1:0] a,
                                      input logic [WB-1:0] b, input int due);
        exp_t          e;
        logic [WA-1:0] m;
        e.id  = id;
        e.due = due;
        e.err = 1'b0;
        if (b == '0) begin
`ifdef DIV_ZERO_ERR_EN
            e.q   = '0;
            e.r   = '0;
            e.err = 1'b1;
`else
            e.q = {WA{1'b1}};
            e.r = a[WB-1:0];
`endif
        end else begin
            e.q = a / WA'(b);
            m   = a % WA'(b);
            e.r = m[WB-1:0];
        end
        return e;
    endfunction

    // One clock of stimulus: drive inputs just after the edge, then check req_ready against the model.
    task automatic applyStimulus(input logic [1:0] v, input logic [WA-1:0] a0, input logic [WB-1:0] b0,
                                 input logic [WA-1:0] a1, input logic [WB-1:0] b1);
        logic [1:0]    exp_rdy;
        logic          g;
        logic [WA-1:0] a;
        logic [WB-1:0] b;
        int            lat;
        @(posedge clk);
        #1;
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        if (!busy) begin
            rsp_ready = 1'($urandom_range(0, 1));
            exp_rdy   = 2'b00;
            g         = 1'b0;
            if (v != 2'b00) begin
                g       = (v == 2'b11) ? ~last : v[1];
                exp_rdy = g ? 2'b10 : 2'b01;
            end
            #1;
            checkOutput("req_ready_idle", 32'(req_ready), 32'(exp_rdy));
            if (v != 2'b00) begin
                last = g;
                a    = g ? a1 : a0;
                b    = g ? b1 : b0;
                lat  = WA;
`ifdef DIV_ZERO_ERR_EN
                if (b == '0) lat = 1;
`endif
                sb.push_back(expectOf(g, a, b, cyc + 1 + lat));
                busy  = 1;
                left  = lat + 1;
                stall = next_stall;
            end
        end else begin
            if (left > 0) left--;
            if (left == 0) begin
                if (stall > 0) begin
                    rsp_ready = 1'b0;
                    stall--;
                end else begin
                    rsp_ready = 1'b1;
                end
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
            #1;
            checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
            if (left == 0 && rsp_ready) busy = 0;
        end
    endtask

    // Present a request pattern and keep it up until the granted transaction has been consumed.
    task automatic runTxn(input logic [1:0] v, input logic [WA-1:0] a0, input logic [WB-1:0] b0,
                          input logic [WA-1:0] a1, input logic [WB-1:0] b1, input int stl);
        int guard;
        next_stall = stl;
        applyStimulus(v, a0, b0, a1, b1);
        guard = 0;
        while (busy && guard < 100) begin
            applyStimulus(v, WA'($urandom), WB'($urandom), WA'($urandom), WB'($urandom));
            guard++;
        end
    endtask

    task automatic pulseReset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_q", 32'(rsp_q), 32'd0);
        checkOutput("rst_rsp_r", 32'(rsp_r), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef DIV_ZERO_ERR_EN
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
`endif
        sb.delete();
        seen = 0;
        busy = 0;
        left = 0;
        last = 1;
        @(negedge clk);
        #1;
        req_valid = 2'b00;
        rst_n     = 1'b1;
    endtask

    // Monitor: compares every cycle the response is presented and retires it on the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        checkOutput("rsp_latency", 32'(cyc), 32'(e.due));
                        seen = 1;
                    end
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_q", 32'(rsp_q), 32'(e.q));
                    checkOutput("rsp_r", 32'(rsp_r), 32'(e.r));
`ifdef DIV_ZERO_ERR_EN
                    checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0]    v;
        logic [WB-1:0] b0;
        logic [WB-1:0] b1;
        #1;
        pulseReset();

        $display("[TB] directed transactions");
        runTxn(2'b01, 8'd200, 4'd7, 8'd0, 4'd0, 0);
        runTxn(2'b10, 8'd0, 4'd0, 8'd5, 4'd9, 0);
        runTxn(2'b01, 8'd255, 4'd1, 8'd0, 4'd0, 0);

        // Abort a division four cycles into RUN; the tie afterwards must go to requester 0.
        next_stall = 0;
        applyStimulus(2'b01, 8'd123, 4'd5, 8'd0, 4'd0);
        repeat (4) applyStimulus(2'b00, 8'd0, 4'd0, 8'd0, 4'd0);
        #1;
        pulseReset();

        runTxn(2'b11, 8'd90, 4'd4, 8'd33, 4'd6, 0);
        runTxn(2'b11, 8'd17, 4'd2, 8'd250, 4'd11, 0);
        runTxn(2'b11, 8'd64, 4'd8, 8'd1, 4'd15, 0);

        runTxn(2'b01, 8'd100, 4'd3, 8'd0, 4'd0, 3);
        runTxn(2'b10, 8'd0, 4'd0, 8'd77, 4'd0, 1);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 150; i++) begin
            v  = 2'($urandom_range(0, 3));
            b0 = ($urandom_range(0, 7) == 0) ? 4'd0 : WB'($urandom_range(1, 15));
            b1 = ($urandom_range(0, 7) == 0) ? 4'd0 : WB'($urandom_range(1, 15));
            runTxn(v, WA'($urandom), b0, WA'($urandom), b1, $urandom_range(0, 3));
        end

        repeat (3) applyStimulus(2'b00, 8'd0, 4'd0, 8'd0, 4'd0);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
